// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared constants, word type and FSM states for the stack host controller
package stack_pkg;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP,
        POP_WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/stack_host_ctrl_if.sv
// rtl/stack_host_ctrl_if.sv - datapath-side write stream, pop request and response port
interface stack_host_ctrl_if;
    import stack_pkg::*;

    logic  wr_valid;
    logic  wr_ready;
    word_t wr_data;
    logic  rd_req;
    logic  rd_valid;
    logic  rd_ready;
    word_t rd_data;
    logic  rd_err;

    modport master (
        output wr_valid, wr_data, rd_req, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_err
    );

    modport slave (
        input  wr_valid, wr_data, rd_req, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_err
    );

endinterface

// File: rtl/stack_occ_cnt.sv
// rtl/stack_occ_cnt.sv - bounded up/down shadow occupancy counter with empty/full compares
module stack_occ_cnt
    import stack_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] occ,
    output logic             empty,
    output logic             full
);

    assign empty = (occ == '0);
    assign full  = (occ == CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            occ <= '0;
        end else if (inc && !dec && !full) begin
            occ <= occ + 1'b1;
        end else if (dec && !inc && !empty) begin
            occ <= occ - 1'b1;
        end
    end

endmodule

// File: rtl/stack_host_ctrl.sv
// rtl/stack_host_ctrl.sv - turns write/pop requests into one-cycle stack commands and returns popped words
module stack_host_ctrl
    import stack_pkg::*;
#(
    parameter int POP_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    stack_host_ctrl_if.slave  host,
    output logic              PushEnbl,
    output logic              PopEnbl,
    output word_t             PushDataIn,
    input  word_t             PopDataOut,
    input  logic              STACK_FULL,
    output logic [CNT_W-1:0]  occ,
    output logic              empty,
    output logic              sync_err
);

    localparam logic [1:0] WAIT_INIT = 2'(POP_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] wait_cnt;
    logic       full;
    logic       pop_go;
    logic       pop_rej;
    logic       push_go;
    logic       wr_ready;
    logic       capture;
    logic       resp_done;
    logic       rd_valid;
    logic       rd_err;
    word_t      rd_data;

    stack_occ_cnt u_occ (
        .clk   (clk),
        .reset (reset),
        .inc   (push_go),
        .dec   (pop_go),
        .occ   (occ),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (pop_go) state_nxt = POP;
                      else if (push_go) state_nxt = PUSH;
            PUSH:     state_nxt = IDLE;
            POP:      state_nxt = POP_WAIT;
            POP_WAIT: if (wait_cnt == 2'd0) state_nxt = RESP;
            RESP:     if (resp_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Pop wins arbitration in IDLE; a rejected pop still lets a write through.
    always_comb begin
        pop_go    = (state == IDLE) && host.rd_req && !empty;
        pop_rej   = (state == IDLE) && host.rd_req && empty;
        wr_ready  = (state == IDLE) && !pop_go && !full && !STACK_FULL;
        push_go   = host.wr_valid && wr_ready;
        capture   = (state == POP_WAIT) && (wait_cnt == 2'd0);
        resp_done = (state == RESP) && rd_valid && host.rd_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            PushEnbl   <= 1'b0;
            PopEnbl    <= 1'b0;
            PushDataIn <= '0;
            wait_cnt   <= 2'd0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_err     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            PushEnbl <= push_go;
            PopEnbl  <= pop_go;
            rd_err   <= pop_rej;
            if (push_go) begin
                PushDataIn <= host.wr_data;
            end
            if (state == POP) begin
                wait_cnt <= WAIT_INIT;
            end else if ((state == POP_WAIT) && (wait_cnt != 2'd0)) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
            if (capture) begin
                rd_data  <= PopDataOut;
                rd_valid <= 1'b1;
            end else if (resp_done) begin
                rd_valid <= 1'b0;
            end
            // The stack only reports full, so compare it against the shadow count when settled.
            if ((state == IDLE) && (STACK_FULL != full)) begin
                sync_err <= 1'b1;
            end
        end
    end

    assign host.wr_ready = wr_ready;
    assign host.rd_valid = rd_valid;
    assign host.rd_data  = rd_data;
    assign host.rd_err   = rd_err;

endmodule

// File: tb/tb_stack_host_ctrl.sv
// tb/tb_stack_host_ctrl.sv - self-checking bench with a behavioural stack and a queue-based reference model
module tb_stack_host_ctrl;
    import stack_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stack_host_ctrl_if host ();

    logic             PushEnbl;
    logic             PopEnbl;
    word_t            PushDataIn;
    word_t            PopDataOut;
    logic             STACK_FULL;
    logic [CNT_W-1:0] occ;
    logic             empty;
    logic             sync_err;

    stack_host_ctrl #(.POP_LAT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .host       (host),
        .PushEnbl   (PushEnbl),
        .PopEnbl    (PopEnbl),
        .PushDataIn (PushDataIn),
        .PopDataOut (PopDataOut),
        .STACK_FULL (STACK_FULL),
        .occ        (occ),
        .empty      (empty),
        .sync_err   (sync_err)
    );

    // Behavioural stack with one cycle of pop latency and an override for the full flag.
    word_t mem [DEPTH];
    int    tos;
    logic  force_en;
    logic  force_val;

    always @(posedge clk) begin
        if (reset) begin
            tos        <= 0;
            PopDataOut <= '0;
        end else begin
            if (PushEnbl && tos < DEPTH) begin
                mem[tos] <= PushDataIn;
                tos      <= tos + 1;
            end
            if (PopEnbl && tos > 0) begin
                PopDataOut <= mem[tos-1];
                tos        <= tos - 1;
            end
        end
    end

    assign STACK_FULL = force_en ? force_val : (tos == DEPTH);

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    logic mon_en    = 1'b0;
    logic prev_push = 1'b0;
    logic prev_pop  = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("enbl_exclusive", {31'd0, PushEnbl & PopEnbl}, 32'd0);
            check("push_pulse_width", {31'd0, PushEnbl & prev_push}, 32'd0);
            check("pop_pulse_width", {31'd0, PopEnbl & prev_pop}, 32'd0);
            prev_push <= PushEnbl;
            prev_pop  <= PopEnbl;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input word_t d);
        int n;
        n = 0;
        host.wr_valid = 1'b1;
        host.wr_data  = d;
        #1;
        while (!host.wr_ready && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("push_ready", {31'd0, host.wr_ready}, 32'd1);
        @(posedge clk);
        #1;
        host.wr_valid = 1'b0;
        check("push_enbl", {31'd0, PushEnbl}, 32'd1);
        check("push_data", {20'd0, PushDataIn}, {20'd0, d});
        step();
    endtask

    task automatic do_pop(output word_t got, output logic err);
        int n;
        got = '0;
        host.rd_req   = 1'b1;
        host.rd_ready = 1'b1;
        step();
        host.rd_req = 1'b0;
        err = host.rd_err;
        if (PopEnbl) begin
            n = 0;
            while (!host.rd_valid && n < 10) begin
                step();
                n++;
            end
            check("pop_latency", n, 32'd2);
            got = host.rd_data;
            step();
            check("rd_valid_clear", {31'd0, host.rd_valid}, 32'd0);
        end else begin
            step();
            check("rd_err_one_cycle", {31'd0, host.rd_err}, 32'd0);
        end
    endtask

    typedef struct {
        bit    is_pop;
        word_t data;
        bit    exp_err;
        int    exp_occ;
    } vec_t;

    vec_t  tbl [$];
    word_t q [$];

    initial begin
        word_t got;
        word_t d;
        logic  err;
        int    n;
        int    seen;

        host.wr_valid = 1'b0;
        host.wr_data  = '0;
        host.rd_req   = 1'b0;
        host.rd_ready = 1'b0;
        force_en      = 1'b0;
        force_val     = 1'b0;
        reset         = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;

        check("rst_occ", {28'd0, occ}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_push_enbl", {31'd0, PushEnbl}, 32'd0);
        check("rst_pop_enbl", {31'd0, PopEnbl}, 32'd0);
        check("rst_push_data", {20'd0, PushDataIn}, 32'd0);
        check("rst_rd_valid", {31'd0, host.rd_valid}, 32'd0);
        check("rst_rd_data", {20'd0, host.rd_data}, 32'd0);
        check("rst_rd_err", {31'd0, host.rd_err}, 32'd0);
        check("rst_sync_err", {31'd0, sync_err}, 32'd0);
        check("rst_wr_ready", {31'd0, host.wr_ready}, 32'd1);
        mon_en = 1'b1;

        // Empty pop
        host.rd_req = 1'b1;
        step();
        host.rd_req = 1'b0;
        check("empty_pop_err", {31'd0, host.rd_err}, 32'd1);
        check("empty_pop_enbl", {31'd0, PopEnbl}, 32'd0);
        check("empty_pop_occ", {28'd0, occ}, 32'd0);
        step();
        check("empty_pop_err_clear", {31'd0, host.rd_err}, 32'd0);
        check("empty_pop_enbl2", {31'd0, PopEnbl}, 32'd0);

        // LIFO table
        tbl.push_back('{0, 12'h111, 0, 1});
        tbl.push_back('{0, 12'h222, 0, 2});
        tbl.push_back('{0, 12'h333, 0, 3});
        tbl.push_back('{1, 12'h333, 0, 2});
        tbl.push_back('{1, 12'h222, 0, 1});
        tbl.push_back('{1, 12'h111, 0, 0});
        tbl.push_back('{1, 12'h000, 1, 0});
        tbl.push_back('{0, 12'hFFF, 0, 1});
        tbl.push_back('{1, 12'hFFF, 0, 0});
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].is_pop) begin
                do_pop(got, err);
                check("tbl_err", {31'd0, err}, {31'd0, tbl[i].exp_err});
                if (!tbl[i].exp_err) check("tbl_rd_data", {20'd0, got}, {20'd0, tbl[i].data});
            end else begin
                do_push(tbl[i].data);
            end
            check("tbl_occ", {28'd0, occ}, tbl[i].exp_occ);
            check("tbl_empty", {31'd0, empty}, {31'd0, tbl[i].exp_occ == 0});
        end

        // Fill to full; a ninth word must be held upstream
        for (int i = 0; i < DEPTH; i++) do_push(word_t'(12'hA00 + i));
        check("full_occ", {28'd0, occ}, DEPTH);
        host.wr_valid = 1'b1;
        host.wr_data  = 12'hBAD;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("full_wr_ready", {31'd0, host.wr_ready}, 32'd0);
            step();
            check("full_no_push", {31'd0, PushEnbl}, 32'd0);
        end
        host.wr_valid = 1'b0;
        check("full_sync_err", {31'd0, sync_err}, 32'd0);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            do_pop(got, err);
            check("drain_data", {20'd0, got}, 32'hA00 + i);
        end
        check("drain_occ", {28'd0, occ}, 32'd0);

        // Pop priority with response back-pressure
        do_push(12'h5A1);
        do_push(12'h5A2);
        host.wr_valid = 1'b1;
        host.wr_data  = 12'h777;
        host.rd_req   = 1'b1;
        host.rd_ready = 1'b0;
        #1;
        check("prio_wr_ready", {31'd0, host.wr_ready}, 32'd0);
        @(posedge clk);
        #1;
        host.rd_req = 1'b0;
        check("prio_pop_enbl", {31'd0, PopEnbl}, 32'd1);
        check("prio_push_enbl", {31'd0, PushEnbl}, 32'd0);
        check("prio_occ", {28'd0, occ}, 32'd1);
        n = 0;
        while (!host.rd_valid && n < 10) begin
            step();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_rd_valid", {31'd0, host.rd_valid}, 32'd1);
            check("bp_rd_data", {20'd0, host.rd_data}, 32'h5A2);
            check("bp_wr_ready", {31'd0, host.wr_ready}, 32'd0);
            step();
        end
        host.rd_ready = 1'b1;
        step();
        check("bp_rd_valid_drop", {31'd0, host.rd_valid}, 32'd0);
        check("bp_wr_ready_after", {31'd0, host.wr_ready}, 32'd1);
        step();
        host.wr_valid = 1'b0;
        check("bp_push_enbl", {31'd0, PushEnbl}, 32'd1);
        check("bp_push_data", {20'd0, PushDataIn}, 32'h777);
        check("bp_occ", {28'd0, occ}, 32'd2);
        step();

        // Stack full flag disagreeing with the shadow count
        do_push(12'h333);
        check("dis_occ", {28'd0, occ}, 32'd3);
        force_en      = 1'b1;
        force_val     = 1'b1;
        host.wr_valid = 1'b1;
        host.wr_data  = 12'h444;
        #1;
        check("dis_wr_ready", {31'd0, host.wr_ready}, 32'd0);
        check("dis_sync_err_pre", {31'd0, sync_err}, 32'd0);
        step();
        check("dis_sync_err_set", {31'd0, sync_err}, 32'd1);
        check("dis_no_push", {31'd0, PushEnbl}, 32'd0);
        force_en      = 1'b0;
        host.wr_valid = 1'b0;
        repeat (3) step();
        check("dis_sync_err_sticky", {31'd0, sync_err}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("dis_sync_err_reset", {31'd0, sync_err}, 32'd0);
        check("dis_occ_reset", {28'd0, occ}, 32'd0);

        // Reset on the cycle PopEnbl is high
        do_push(12'h4C4);
        do_push(12'h4C5);
        host.rd_req   = 1'b1;
        host.rd_ready = 1'b1;
        step();
        host.rd_req = 1'b0;
        check("mid_pop_enbl", {31'd0, PopEnbl}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_pop_enbl_rst", {31'd0, PopEnbl}, 32'd0);
        check("mid_push_enbl_rst", {31'd0, PushEnbl}, 32'd0);
        check("mid_push_data_rst", {20'd0, PushDataIn}, 32'd0);
        check("mid_rd_valid_rst", {31'd0, host.rd_valid}, 32'd0);
        check("mid_rd_data_rst", {20'd0, host.rd_data}, 32'd0);
        check("mid_rd_err_rst", {31'd0, host.rd_err}, 32'd0);
        check("mid_occ_rst", {28'd0, occ}, 32'd0);
        check("mid_sync_err_rst", {31'd0, sync_err}, 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (host.rd_valid) seen = 1;
            step();
        end
        check("mid_no_response", seen, 32'd0);
        check("mid_idle_wr_ready", {31'd0, host.wr_ready}, 32'd1);

        // Randomised push/pop against a queue model
        q.delete();
        for (int i = 0; i < 80; i++) begin
            d = word_t'($urandom_range(0, 4095));
            if ($urandom_range(0, 9) < 6) begin
                if (q.size() < DEPTH) begin
                    do_push(d);
                    q.push_back(d);
                end else begin
                    host.wr_valid = 1'b1;
                    host.wr_data  = d;
                    #1;
                    check("rnd_full_ready", {31'd0, host.wr_ready}, 32'd0);
                    step();
                    host.wr_valid = 1'b0;
                    check("rnd_full_no_push", {31'd0, PushEnbl}, 32'd0);
                end
            end else begin
                do_pop(got, err);
                if (q.size() == 0) begin
                    check("rnd_pop_err", {31'd0, err}, 32'd1);
                end else begin
                    check("rnd_pop_err", {31'd0, err}, 32'd0);
                    d = q.pop_back();
                    check("rnd_pop_data", {20'd0, got}, {20'd0, d});
                end
            end
            check("rnd_occ", {28'd0, occ}, q.size());
            check("rnd_empty", {31'd0, empty}, {31'd0, q.size() == 0});
        end
        check("rnd_sync_err", {31'd0, sync_err}, 32'd0);

        mon_en = 1'b0;
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
